// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller blocks.
// Holds the phase encoding and the round-robin helper used by the arbiter.
package tlc_pkg;

  typedef enum logic [1:0] {
    PH_NS  = 2'd0,
    PH_EW  = 2'd1,
    PH_PED = 2'd2
  } phase_t;

  localparam int unsigned NUM_REQ       = 3;
  localparam int unsigned DEF_DEB_TICKS = 2;
  localparam int unsigned DEF_MAX_WAIT  = 8;
  localparam int unsigned DEF_WAIT_W    = 4;

  // First set bit of mask searching NS -> EW -> PED, starting just after last.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                         input logic [1:0]         last);
    logic [3:0] m4;
    logic [1:0] idx;
    logic [1:0] res;
    m4  = {1'b0, mask};
    res = last;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % 3);
      if (m4[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/tlc_phase_arbiter_input_debouncer.sv
// Tick-based debouncer: output follows the synchronised input only after it
// has differed from the current level on DEB_TICKS consecutive clk_en ticks.
module input_debouncer #(
  parameter int unsigned DEB_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic din_sync,
  output logic dout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (clk_en) begin
      if (din_sync != dout_q) begin
        if (cnt_q >= CNT_LAST) begin
          dout_d = din_sync;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/tlc_phase_arbiter.sv
// Request arbiter for the phase sequencer: sync + debounce of the switch
// inputs, sticky pending requests, aging, round-robin pick, valid/ready grant.
module tlc_phase_arbiter
  import tlc_pkg::*;
#(
  parameter int unsigned DEB_TICKS = DEF_DEB_TICKS,
  parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
  parameter int unsigned WAIT_W    = DEF_WAIT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped,
  input  logic       phase_ready,
  output logic       grant_valid,
  output logic [1:0] grant_phase,
  output logic [2:0] pending,
  output logic       starved
);

  localparam logic [WAIT_W-1:0] MAX_AGE = WAIT_W'(MAX_WAIT);

  logic [NUM_REQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_REQ-1:0] deb;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [WAIT_W-1:0]  age_q [NUM_REQ];
  logic [WAIT_W-1:0]  age_d [NUM_REQ];
  logic               starved_q, starved_d;
  logic               grant_valid_q, grant_valid_d;
  logic [1:0]         grant_phase_q, grant_phase_d;
  logic [1:0]         last_q, last_d;

  logic               accept;
  logic [NUM_REQ-1:0] acc_vec;
  logic [NUM_REQ-1:0] starved_vec;
  logic [NUM_REQ-1:0] sel_mask;
  logic [1:0]         sel;

  always_comb begin
    sync1_d = {ped, car_ew, car_ns};
    sync2_d = sync1_q;
  end

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_deb
    input_debouncer #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .din_sync (sync2_q[g]),
      .dout     (deb[g])
    );
  end

  // Pending, aging and starvation; an accept always beats a set or an increment.
  always_comb begin
    accept    = grant_valid_q & phase_ready;
    starved_d = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      acc_vec[i]     = accept && (grant_phase_q == 2'(i));
      pending_d[i]   = (pending_q[i] | deb[i]) & ~acc_vec[i];
      starved_vec[i] = pending_q[i] && (age_q[i] >= MAX_AGE);
      age_d[i]       = age_q[i];
      if (acc_vec[i] || !pending_q[i]) begin
        age_d[i] = '0;
      end else if (clk_en && (age_q[i] < MAX_AGE)) begin
        age_d[i] = age_q[i] + WAIT_W'(1);
      end
      starved_d = starved_d | (pending_d[i] && (age_d[i] >= MAX_AGE));
    end
  end

  // Starved requests all sit at the saturated age, so round-robin breaks the tie.
  always_comb begin
    sel_mask = (|starved_vec) ? starved_vec : pending_q;
    sel      = rr_pick(sel_mask, last_q);
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_phase_d = grant_phase_q;
    last_d        = last_q;
    if (accept) begin
      grant_valid_d = 1'b0;
      last_d        = grant_phase_q;
    end else if (!grant_valid_q && (|pending_q)) begin
      grant_valid_d = 1'b1;
      grant_phase_d = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      pending_q     <= '0;
      starved_q     <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_phase_q <= 2'(PH_NS);
      last_q        <= 2'(PH_PED);
      for (int i = 0; i < int'(NUM_REQ); i++) age_q[i] <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      pending_q     <= pending_d;
      starved_q     <= starved_d;
      grant_valid_q <= grant_valid_d;
      grant_phase_q <= grant_phase_d;
      last_q        <= last_d;
      for (int i = 0; i < int'(NUM_REQ); i++) age_q[i] <= age_d[i];
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_phase = grant_phase_q;
  assign pending     = pending_q;
  assign starved     = starved_q;

endmodule
